// File: rtl/row_scan_if.sv
// Bundles the requester, memory_reader and output-stream signals of row_scan_scheduler.
// The master side is the requesters/reader/consumer; the slave side is the scheduler.
interface row_scan_if #(
    parameter int WORD_WIDTH = 512
);
    logic [1:0]            req_valid;
    logic [1:0][7:0]       req_start;
    logic [1:0][8:0]       req_count;
    logic [1:0]            req_ready;
    logic                  scan_en;
    logic [7:0]            row_counter;
    logic [WORD_WIDTH-1:0] data_in;
    logic                  scan_done;
    logic                  out_valid;
    logic                  out_ready;
    logic [WORD_WIDTH-1:0] out_data;
    logic                  out_id;
    logic                  out_last;

    modport master (
        output req_valid, req_start, req_count, data_in, scan_done, out_ready,
        input  req_ready, scan_en, row_counter, out_valid, out_data, out_id, out_last
    );

    modport slave (
        input  req_valid, req_start, req_count, data_in, scan_done, out_ready,
        output req_ready, scan_en, row_counter, out_valid, out_data, out_id, out_last
    );
endinterface

// File: rtl/row_scan_scheduler.sv
// Round-robin scheduler for the shared memory_reader row-scan port: scans a row range
// one row at a time and streams each word out tagged with requester ID and last flag.
module row_scan_scheduler #(
    parameter int WORD_WIDTH = 512,
    parameter int NUM_ROWS   = 128
) (
    input  logic           clock,
    input  logic           reset,
    row_scan_if.slave      bus,
    output logic           busy
);
    localparam logic [7:0] ROW_MASK  = 8'(NUM_ROWS - 1);
    localparam logic [8:0] MAX_COUNT = 9'(NUM_ROWS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_ptr;
    logic                  r_id;
    logic [7:0]            r_row;
    logic [8:0]            r_rem;
    logic [WORD_WIDTH-1:0] r_out_data;
    logic                  r_out_id;
    logic                  r_out_last;

    logic                  w_winner;
    logic [1:0]            w_ready;
    logic                  w_accept;
    logic [7:0]            w_start;
    logic [8:0]            w_count;

    // Arbitration: r_ptr names the requester favoured when both are pending.
    always_comb begin
        w_winner = 1'b0;
        w_ready  = 2'b00;
        if (bus.req_valid == 2'b11) begin
            w_winner = r_ptr;
        end else if (bus.req_valid[1]) begin
            w_winner = 1'b1;
        end else begin
            w_winner = 1'b0;
        end
        if ((r_state == IDLE) && reset && (bus.req_valid != 2'b00)) begin
            w_ready = w_winner ? 2'b10 : 2'b01;
        end else begin
            w_ready = 2'b00;
        end
        w_accept = (w_ready != 2'b00);
        w_start  = bus.req_start[w_winner] & ROW_MASK;
        if (bus.req_count[w_winner] > MAX_COUNT) begin
            w_count = MAX_COUNT;
        end else begin
            w_count = bus.req_count[w_winner];
        end
    end

    // Next-state logic; a zero-length range is accepted without leaving IDLE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept && (w_count != 9'd0)) w_next = SCAN;
                else                               w_next = IDLE;
            end
            SCAN: begin
                if (bus.scan_done) w_next = OUT;
                else               w_next = SCAN;
            end
            OUT: begin
                if (bus.out_ready) w_next = r_out_last ? IDLE : SCAN;
                else               w_next = OUT;
            end
            default: w_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Range bookkeeping and the captured output word.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_ptr      <= 1'b0;
            r_id       <= 1'b0;
            r_row      <= 8'd0;
            r_rem      <= 9'd0;
            r_out_data <= '0;
            r_out_id   <= 1'b0;
            r_out_last <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_id  <= w_winner;
                        r_row <= w_start;
                        r_rem <= w_count;
                        r_ptr <= ~w_winner;
                    end
                end
                SCAN: begin
                    if (bus.scan_done) begin
                        r_out_data <= bus.data_in;
                        r_out_id   <= r_id;
                        r_out_last <= (r_rem == 9'd1);
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        r_row <= (r_row + 8'd1) & ROW_MASK;
                        if (r_rem != 9'd0) r_rem <= r_rem - 9'd1;
                        else               r_rem <= r_rem;
                    end
                end
                default: begin
                    r_row <= r_row;
                end
            endcase
        end
    end

    assign bus.req_ready   = w_ready;
    assign bus.scan_en     = (r_state == SCAN);
    assign bus.row_counter = r_row;
    assign bus.out_valid   = (r_state == OUT);
    assign bus.out_data    = r_out_data;
    assign bus.out_id      = r_out_id;
    assign bus.out_last    = r_out_last;
    assign busy            = (r_state != IDLE);
endmodule

// File: tb/tb_row_scan_scheduler.sv
// Self-checking bench for row_scan_scheduler: directed scenarios pinned by literals,
// then randomized traffic compared every cycle against a transaction-level model.
module tb_row_scan_scheduler;
    localparam int WW = 512;
    localparam int NR = 128;

    logic clock = 1'b0;
    logic reset;
    logic busy;

    row_scan_if #(.WORD_WIDTH(WW)) bus();

    row_scan_scheduler #(.WORD_WIDTH(WW), .NUM_ROWS(NR)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave),
        .busy  (busy)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    logic       k_reset;
    logic [1:0] k_valid;
    logic [7:0] k_start [2];
    logic [8:0] k_count [2];
    logic       k_ready;
    bit         rnd_mode;
    int         lat_age;

    int          m_pend;
    int          m_row;
    bit          m_id;
    bit          m_ptr;
    bit          m_have;
    bit          m_last;
    bit          m_wid;
    logic [WW-1:0] m_word;
    bit          acc_flag;

    int row_log[$];
    int grant_log[$];
    int last_log[$];
    int id_log[$];
    int word_cnt;
    int scan_cycles;

    task automatic chk(string name, logic [WW-1:0] act, logic [WW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One clock cycle: drive inputs at negedge, compare against the model, then advance it.
    task automatic step();
        logic [WW-1:0] d;
        logic [1:0]    exp_ready;
        int            w;
        int            cnt;
        @(negedge clock);
        if (bus.scan_en) lat_age++;
        else             lat_age = 0;
        for (int i = 0; i < WW / 32; i++) d[i*32 +: 32] = $urandom;
        bus.data_in = d;
        if (rnd_mode) begin
            reset         = ($urandom_range(0, 399) != 0);
            bus.req_valid = 2'($urandom_range(0, 3));
            for (int i = 0; i < 2; i++) begin
                bus.req_start[i] = 8'($urandom);
                bus.req_count[i] = ($urandom_range(0, 29) == 0) ? 9'($urandom_range(129, 511))
                                                                : 9'($urandom_range(0, 5));
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.scan_done = bus.scan_en ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
        end else begin
            reset         = k_reset;
            bus.req_valid = k_valid;
            for (int i = 0; i < 2; i++) begin
                bus.req_start[i] = k_start[i];
                bus.req_count[i] = k_count[i];
            end
            bus.out_ready = k_ready;
            bus.scan_done = bus.scan_en && (lat_age >= 2);
        end
        #1;
        w = (bus.req_valid == 2'b11) ? int'(m_ptr) : (bus.req_valid[1] ? 1 : 0);
        exp_ready = 2'b00;
        if (reset && (m_pend == 0) && (bus.req_valid != 2'b00)) exp_ready = (w == 1) ? 2'b10 : 2'b01;
        chk("req_ready", WW'(bus.req_ready), WW'(exp_ready));
        chk("scan_en", WW'(bus.scan_en), WW'((m_pend > 0) && !m_have));
        chk("busy", WW'(busy), WW'(m_pend > 0));
        chk("out_valid", WW'(bus.out_valid), WW'(m_have));
        if ((m_pend > 0) && !m_have) chk("row_counter", WW'(bus.row_counter), WW'(m_row));
        if (m_have) begin
            chk("out_data", bus.out_data, m_word);
            chk("out_id", WW'(bus.out_id), WW'(m_wid));
            chk("out_last", WW'(bus.out_last), WW'(m_last));
        end
        if (bus.scan_en) scan_cycles++;
        if (bus.scan_en && bus.scan_done) row_log.push_back(int'(bus.row_counter));
        if ((bus.req_ready & bus.req_valid) != 2'b00) grant_log.push_back(bus.req_ready[1] ? 1 : 0);
        if (bus.out_valid && bus.out_ready) begin
            word_cnt++;
            last_log.push_back(int'(bus.out_last));
            id_log.push_back(int'(bus.out_id));
        end
        acc_flag = 1'b0;
        if (!reset) begin
            m_pend = 0;
            m_have = 1'b0;
            m_ptr  = 1'b0;
        end else if (m_pend == 0) begin
            if (bus.req_valid != 2'b00) begin
                acc_flag = 1'b1;
                m_id     = (w == 1);
                m_row    = int'(bus.req_start[w]) % NR;
                cnt      = int'(bus.req_count[w]);
                m_pend   = (cnt > NR) ? NR : cnt;
                m_ptr    = (w == 0);
            end
        end else if (!m_have) begin
            if (bus.scan_done) begin
                m_have = 1'b1;
                m_word = bus.data_in;
                m_last = (m_pend == 1);
                m_wid  = m_id;
            end
        end else if (bus.out_ready) begin
            m_have = 1'b0;
            m_pend--;
            m_row  = (m_row + 1) % NR;
        end
    endtask

    task automatic wait_idle(string name);
        for (int n = 0; n < 3000 && m_pend != 0; n++) step();
        if (m_pend != 0) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=busy required=idle", name);
        end
    endtask

    task automatic post_req(int id, int start, int count);
        k_valid     = 2'b00;
        k_valid[id] = 1'b1;
        k_start[id] = 8'(start);
        k_count[id] = 9'(count);
        acc_flag    = 1'b0;
        for (int n = 0; n < 50 && !acc_flag; n++) step();
        if (!acc_flag) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout actual=no_grant required=grant id=%0d", id);
        end
        k_valid = 2'b00;
    endtask

    task automatic run_req(int id, int start, int count);
        post_req(id, start, count);
        wait_idle("range");
        step();
    endtask

    initial begin
        int sc;
        int gl;
        rnd_mode = 1'b0;
        k_reset  = 1'b0;
        k_valid  = 2'b11;
        k_ready  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            k_start[i] = 8'd0;
            k_count[i] = 9'd1;
        end
        reset         = 1'b0;
        bus.req_valid = 2'b00;
        bus.req_start = '0;
        bus.req_count = '0;
        bus.data_in   = '0;
        bus.scan_done = 1'b0;
        bus.out_ready = 1'b0;
        m_pend = 0; m_row = 0; m_id = 1'b0; m_ptr = 1'b0; m_have = 1'b0;
        m_last = 1'b0; m_wid = 1'b0; m_word = '0; lat_age = 0;
        word_cnt = 0; scan_cycles = 0;
        repeat (2) @(posedge clock);
        repeat (3) step();
        chk("rst_req_ready", WW'(bus.req_ready), WW'(2'b00));
        chk("rst_row_counter", WW'(bus.row_counter), WW'(8'd0));
        chk("rst_out_data", bus.out_data, '0);
        chk("rst_out_id", WW'(bus.out_id), WW'(1'b0));
        chk("rst_out_last", WW'(bus.out_last), WW'(1'b0));
        k_valid = 2'b00;
        k_reset = 1'b1;
        step();

        // Single range 5..7 from requester 0.
        row_log.delete(); id_log.delete(); last_log.delete();
        run_req(0, 5, 3);
        chk("single_rows_n", WW'(row_log.size()), WW'(3));
        if (row_log.size() == 3) begin
            chk("single_row0", WW'(row_log[0]), WW'(5));
            chk("single_row1", WW'(row_log[1]), WW'(6));
            chk("single_row2", WW'(row_log[2]), WW'(7));
            chk("single_last", WW'({last_log[0][0], last_log[1][0], last_log[2][0]}), WW'(3'b001));
            chk("single_id", WW'({id_log[0][0], id_log[1][0], id_log[2][0]}), WW'(3'b000));
        end

        // Wrap-around from requester 1.
        row_log.delete(); id_log.delete();
        run_req(1, 126, 4);
        chk("wrap_rows_n", WW'(row_log.size()), WW'(4));
        if (row_log.size() == 4) begin
            chk("wrap_row0", WW'(row_log[0]), WW'(126));
            chk("wrap_row1", WW'(row_log[1]), WW'(127));
            chk("wrap_row2", WW'(row_log[2]), WW'(0));
            chk("wrap_row3", WW'(row_log[3]), WW'(1));
            chk("wrap_id", WW'(id_log[3]), WW'(1));
        end

        // Count saturation.
        word_cnt = 0;
        run_req(0, 3, 200);
        chk("saturate_words", WW'(word_cnt), WW'(128));

        // Zero-length request: a grant but no scan.
        sc = scan_cycles;
        gl = grant_log.size();
        run_req(1, 9, 0);
        chk("zero_no_scan", WW'(scan_cycles), WW'(sc));
        chk("zero_grant", WW'(grant_log.size()), WW'(gl + 1));

        // Reset while scanning row 2 of 4; pointer then favours requester 1 until reset.
        post_req(0, 20, 4);
        for (int n = 0; n < 100 && !(bus.scan_en && bus.row_counter == 8'd21); n++) step();
        chk("midrst_reached", WW'(bus.scan_en && bus.row_counter == 8'd21), WW'(1'b1));
        k_reset = 1'b0;
        step();
        k_reset = 1'b1;
        step();
        chk("midrst_scan_en", WW'(bus.scan_en), WW'(1'b0));
        chk("midrst_out_valid", WW'(bus.out_valid), WW'(1'b0));
        chk("midrst_busy", WW'(busy), WW'(1'b0));

        // Arbitration: both pending continuously, grants alternate from requester 0.
        grant_log.delete();
        k_count[0] = 9'd1; k_count[1] = 9'd1;
        k_start[0] = 8'd30; k_start[1] = 8'd40;
        k_valid = 2'b11;
        for (int n = 0; n < 80 && grant_log.size() < 4; n++) step();
        k_valid = 2'b00;
        wait_idle("arb");
        chk("arb_grants_n", WW'(grant_log.size() >= 4), WW'(1'b1));
        if (grant_log.size() >= 4) begin
            chk("arb_g0", WW'(grant_log[0]), WW'(0));
            chk("arb_g1", WW'(grant_log[1]), WW'(1));
            chk("arb_g2", WW'(grant_log[2]), WW'(0));
            chk("arb_g3", WW'(grant_log[3]), WW'(1));
        end

        // Backpressure on the first word.
        k_ready  = 1'b0;
        word_cnt = 0;
        post_req(0, 50, 2);
        for (int n = 0; n < 50 && !bus.out_valid; n++) step();
        sc = scan_cycles;
        repeat (10) step();
        chk("bp_no_scan", WW'(scan_cycles), WW'(sc));
        chk("bp_busy", WW'(busy), WW'(1'b1));
        k_ready = 1'b1;
        wait_idle("bp");
        step();
        chk("bp_words", WW'(word_cnt), WW'(2));

        // Randomized traffic including stray scan_done and occasional reset.
        rnd_mode = 1'b1;
        repeat (4000) step();
        rnd_mode = 1'b0;
        k_valid  = 2'b00;
        k_reset  = 1'b1;
        k_ready  = 1'b1;
        wait_idle("drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
